// File: rtl/i2c_init_seq.sv
// Walks a register table and writes each entry to an external I2C device through an
// OpenCores-style I2C master core over Wishbone, with NACK retry and error abort.
module i2c_init_seq #(
  parameter logic [6:0]  DEV_ADDR   = 7'h2A,
  parameter int unsigned N_REGS     = 64,
  parameter int unsigned IDX_W      = 8,
  parameter logic [15:0] PRESCALE   = 16'h0063,
  parameter int unsigned MAX_RETRY  = 3,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] cfg_idx,
  input  logic [15:0]      cfg_word,
  output logic [2:0]       adr,
  output logic [7:0]       dout,
  input  logic [7:0]       din,
  output logic             we,
  output logic             stb,
  output logic             cyc,
  output logic             sel,
  input  logic             ack,
  input  logic             err,
  input  logic             rty,
  output logic             busy,
  output logic             Finish,
  output logic             error,
  output logic [IDX_W-1:0] fail_idx
);

  localparam int unsigned     RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REGS - 1);
  localparam logic [RW-1:0]    RMAX = RW'(MAX_RETRY);

  typedef enum logic [4:0] {
    IDLE, PRE_LO, PRE_HI, EN, LD_DEV, CMD_DEV, POLL_A, LD_REG, CMD_REG, POLL_B,
    LD_DAT, CMD_DAT, POLL_C, NXT, STOP, POLL_BUSY, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, fail_q, fail_d;
  logic [RW-1:0]    rtry_q, rtry_d;
  logic             fin_q, fin_d, err_q, err_d;
  logic             cyc_q, cyc_d, we_q, we_d, kick_q;
  logic [2:0]       adr_q, adr_d, acc_adr;
  logic [7:0]       dout_q, dout_d, acc_dout;
  logic             acc_we;
  logic             unused_din;

  assign unused_din = ^{din[5:2], din[0]};

  // Bus access owned by each state; IDLE, NXT and DONE do not touch the bus.
  always_comb begin
    acc_adr  = '0;
    acc_dout = '0;
    acc_we   = 1'b0;
    case (state_q)
      PRE_LO:  begin acc_adr = 3'd0; acc_dout = PRESCALE[7:0];    acc_we = 1'b1; end
      PRE_HI:  begin acc_adr = 3'd1; acc_dout = PRESCALE[15:8];   acc_we = 1'b1; end
      EN:      begin acc_adr = 3'd2; acc_dout = 8'h80;            acc_we = 1'b1; end
      LD_DEV:  begin acc_adr = 3'd3; acc_dout = {DEV_ADDR, 1'b0}; acc_we = 1'b1; end
      CMD_DEV: begin acc_adr = 3'd4; acc_dout = 8'h90;            acc_we = 1'b1; end
      LD_REG:  begin acc_adr = 3'd3; acc_dout = cfg_word[15:8];   acc_we = 1'b1; end
      CMD_REG: begin acc_adr = 3'd4; acc_dout = 8'h10;            acc_we = 1'b1; end
      LD_DAT:  begin acc_adr = 3'd3; acc_dout = cfg_word[7:0];    acc_we = 1'b1; end
      CMD_DAT: begin acc_adr = 3'd4; acc_dout = 8'h50;            acc_we = 1'b1; end
      STOP:    begin acc_adr = 3'd4; acc_dout = 8'h40;            acc_we = 1'b1; end
      POLL_A, POLL_B, POLL_C, POLL_BUSY: acc_adr = 3'd4;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    rtry_d  = rtry_q;
    fin_d   = fin_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    if (state_q == IDLE) begin
      if (start || kick_q) begin
        state_d = PRE_LO;
        fin_d   = 1'b0;
        err_d   = 1'b0;
        idx_d   = '0;
        rtry_d  = '0;
      end
    end else if (state_q == NXT) begin
      rtry_d = '0;
      if (idx_q == LAST) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = LD_DEV;
      end
    end else if (state_q == DONE) begin
      fin_d   = 1'b1;
      state_d = IDLE;
    end else if (!cyc_q) begin
      // First cycle in a bus state (or after a rty idle): launch the access.
      cyc_d  = 1'b1;
      adr_d  = acc_adr;
      dout_d = acc_dout;
      we_d   = acc_we;
    end else if (err) begin
      cyc_d   = 1'b0;
      err_d   = 1'b1;
      fail_d  = idx_q;
      state_d = IDLE;
    end else if (rty) begin
      cyc_d = 1'b0;
    end else if (ack) begin
      cyc_d = 1'b0;
      case (state_q)
        PRE_LO:  state_d = PRE_HI;
        PRE_HI:  state_d = EN;
        EN:      state_d = LD_DEV;
        LD_DEV:  state_d = CMD_DEV;
        CMD_DEV: state_d = POLL_A;
        POLL_A:  if (!din[1]) state_d = din[7] ? STOP : LD_REG;
        LD_REG:  state_d = CMD_REG;
        CMD_REG: state_d = POLL_B;
        POLL_B:  if (!din[1]) state_d = din[7] ? STOP : LD_DAT;
        LD_DAT:  state_d = CMD_DAT;
        CMD_DAT: state_d = POLL_C;
        POLL_C:  if (!din[1]) state_d = din[7] ? STOP : NXT;
        STOP:    state_d = POLL_BUSY;
        POLL_BUSY: begin
          if (!din[6]) begin
            if (rtry_q < RMAX) begin
              rtry_d  = rtry_q + RW'(1);
              state_d = LD_DEV;
            end else begin
              err_d   = 1'b1;
              fail_d  = idx_q;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fail_q  <= '0;
      rtry_q  <= '0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dout_q  <= '0;
      kick_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      rtry_q  <= rtry_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      kick_q  <= 1'b0;
    end
  end

  assign cfg_idx  = idx_q;
  assign adr      = adr_q;
  assign dout     = dout_q;
  assign we       = we_q;
  assign cyc      = cyc_q;
  assign stb      = cyc_q;
  assign sel      = cyc_q;
  assign busy     = (state_q != IDLE);
  assign Finish   = fin_q;
  assign error    = err_q;
  assign fail_idx = fail_q;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench: two instances (auto-start N_REGS=2, manual-start N_REGS=8) share one
// Wishbone responder that models the I2C core's SR and injects NACK/rty/err.
module tb_i2c_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, start_a = 1'b0, start_b = 1'b0, act = 1'b0;
  logic [7:0] cfg_idx_a, cfg_idx_b, dout_a, dout_b, fail_idx_a, fail_idx_b;
  logic [2:0] adr_a, adr_b;
  logic we_a, stb_a, cyc_a, sel_a, busy_a, finish_a, error_a;
  logic we_b, stb_b, cyc_b, sel_b, busy_b, finish_b, error_b;
  logic [15:0] cfg_word_a, cfg_word_b;
  logic [7:0] din_r = 8'h00;
  logic ack_r = 1'b0, err_r = 1'b0, rty_r = 1'b0;

  assign cfg_word_a = {8'h30 | cfg_idx_a, 8'hC0 | cfg_idx_a};
  assign cfg_word_b = {8'h30 | cfg_idx_b, 8'hC0 | cfg_idx_b};

  i2c_init_seq #(.N_REGS(2), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .cfg_idx(cfg_idx_a), .cfg_word(cfg_word_a),
    .adr(adr_a), .dout(dout_a), .din(din_r), .we(we_a), .stb(stb_a), .cyc(cyc_a), .sel(sel_a),
    .ack(ack_r & ~act), .err(err_r & ~act), .rty(rty_r & ~act),
    .busy(busy_a), .Finish(finish_a), .error(error_a), .fail_idx(fail_idx_a));

  i2c_init_seq #(.N_REGS(8), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .cfg_idx(cfg_idx_b), .cfg_word(cfg_word_b),
    .adr(adr_b), .dout(dout_b), .din(din_r), .we(we_b), .stb(stb_b), .cyc(cyc_b), .sel(sel_b),
    .ack(ack_r & act), .err(err_r & act), .rty(rty_r & act),
    .busy(busy_b), .Finish(finish_b), .error(error_b), .fail_idx(fail_idx_b));

  logic [2:0] adr_m;
  logic [7:0] dout_m, idx_m;
  logic cyc_m, stb_m, sel_m, we_m, busy_m, fin_m, err_m, rst_m;
  assign adr_m  = act ? adr_b : adr_a;
  assign dout_m = act ? dout_b : dout_a;
  assign idx_m  = act ? cfg_idx_b : cfg_idx_a;
  assign cyc_m  = act ? cyc_b : cyc_a;
  assign stb_m  = act ? stb_b : stb_a;
  assign sel_m  = act ? sel_b : sel_a;
  assign we_m   = act ? we_b : we_a;
  assign busy_m = act ? busy_b : busy_a;
  assign fin_m  = act ? finish_b : finish_a;
  assign err_m  = act ? error_b : error_a;
  assign rst_m  = act ? rst_b : rst_a;

  int cnt = 0;
  always @(posedge clk) cnt++;

  // Responder state (written only by the responder process).
  int wn = 0, proto_bad = 0, nack_used = 0, rty_used = 0, err_used = 0;
  int rty_cyc = -1, re_cyc = -1, wait_n = 0;
  logic [2:0] wadr [0:511];
  logic [7:0] wdat [0:511];
  logic [7:0] last_cmd = 8'h00, l_dout;
  logic [2:0] l_adr, re_adr;
  logic [7:0] re_dout;
  logic l_we, re_we, rd_phase = 1'b0, resp_prev = 1'b0, rty_pend = 1'b0;

  // Fault controls (written only by the initial block).
  int nack_budget = 0, rty_budget = 0, err_budget = 0;
  logic nack_dev_all = 1'b0;
  logic [7:0] err_idx = 8'd5;

  always @(negedge clk) begin
    ack_r = 1'b0; err_r = 1'b0; rty_r = 1'b0;
    if (!rst_m) rd_phase = 1'b0;
    if (stb_m !== cyc_m || sel_m !== cyc_m) proto_bad++;
    if (cyc_m && resp_prev) proto_bad++;
    resp_prev = 1'b0;
    if (!cyc_m) begin
      wait_n = 0;
    end else if (wait_n == 0) begin
      wait_n = 1;
      l_adr = adr_m; l_dout = dout_m; l_we = we_m;
      if (rty_pend) begin
        re_cyc = cnt; re_adr = adr_m; re_dout = dout_m; re_we = we_m; rty_pend = 1'b0;
      end
    end else begin
      if (adr_m !== l_adr || dout_m !== l_dout || we_m !== l_we) proto_bad++;
      wait_n = 0;
      resp_prev = 1'b1;
      if (rty_used < rty_budget && we_m && adr_m == 3'd1) begin
        rty_r = 1'b1; rty_used++; rty_cyc = cnt; rty_pend = 1'b1;
      end else if (err_used < err_budget && we_m && adr_m == 3'd4 && dout_m == 8'h50
                   && idx_m == err_idx) begin
        err_r = 1'b1; err_used++;
      end else begin
        ack_r = 1'b1;
        if (we_m) begin
          if (wn < 512) begin wadr[wn] = adr_m; wdat[wn] = dout_m; end
          wn++;
          if (adr_m == 3'd4) last_cmd = dout_m;
        end else begin
          if (!rd_phase) din_r = 8'h42;
          else if (last_cmd == 8'h40) din_r = 8'h00;
          else if (last_cmd == 8'h90 && nack_dev_all) din_r = 8'h80;
          else if (last_cmd == 8'h10 && idx_m == 8'd1 && nack_used < nack_budget) begin
            din_r = 8'h80; nack_used++;
          end else din_r = 8'h00;
          rd_phase = ~rd_phase;
        end
      end
    end
  end

  int nchk = 0, npass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    if (act) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while ((!(fin_m || err_m) || busy_m) && t < 20000) begin
      @(posedge clk); #1; t++;
    end
    chk(tag, 64'(t < 20000), 64'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, act ? {cyc_b, stb_b, we_b, sel_b, adr_b, dout_b, cfg_idx_b, busy_b, finish_b, error_b, fail_idx_b}
                 : {cyc_a, stb_a, we_a, sel_a, adr_a, dout_a, cfg_idx_a, busy_a, finish_a, error_a, fail_idx_a},
        64'd0);
  endtask

  function automatic int count_wr(input int from, input logic [7:0] val);
    int n = 0;
    for (int i = from; i < wn; i++) if (wadr[i] == 3'd4 && wdat[i] == val) n++;
    return n;
  endfunction

  logic [2:0] ea [0:14] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd4,
                            3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd4};
  logic [7:0] ed [0:14] = '{8'h63, 8'h00, 8'h80, 8'h54, 8'h90, 8'h30, 8'h10, 8'hC0, 8'h50,
                            8'h54, 8'h90, 8'h31, 8'h10, 8'hC1, 8'h50};

  initial begin
    int base, t;
    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_reset("a_reset_vals");

    // Nominal auto-started run; a start while busy must be ignored
    @(negedge clk) rst_a = 1'b1;
    repeat (30) @(posedge clk);
    #1 chk("a_busy_mid", 64'(busy_a), 64'd1);
    pulse_start();
    wait_done("a_nom_timeout");
    chk("a_nom_count", 64'(wn), 64'd15);
    for (int i = 0; i < 15; i++)
      chk($sformatf("a_nom_wr%0d", i), {wadr[i], wdat[i]}, {ea[i], ed[i]});
    chk("a_nom_flags", {finish_a, error_a, busy_a, cfg_idx_a}, {1'b1, 1'b0, 1'b0, 8'd1});

    // One NACK on the CMD_REG poll of entry 1
    base = wn; nack_budget = nack_used + 1;
    pulse_start();
    wait_done("a_nack1_timeout");
    chk("a_nack1_count", 64'(wn - base), 64'd20);
    chk("a_nack1_stop", {wadr[base+13], wdat[base+13]}, {3'd4, 8'h40});
    chk("a_nack1_reld", {wadr[base+14], wdat[base+14], wadr[base+15], wdat[base+15]},
        {3'd3, 8'h54, 3'd4, 8'h90});
    chk("a_nack1_tail", {wadr[base+16], wdat[base+16], wadr[base+18], wdat[base+18]},
        {3'd3, 8'h31, 3'd3, 8'hC1});
    chk("a_nack1_flags", {finish_a, error_a}, {1'b1, 1'b0});

    // Permanent NACK on entry 0: 1 try + 3 retries, then abort
    base = wn; nack_dev_all = 1'b1;
    pulse_start();
    wait_done("a_perm_timeout");
    nack_dev_all = 1'b0;
    chk("a_perm_count", 64'(wn - base), 64'd15);
    chk("a_perm_addr_phases", 64'(count_wr(base, 8'h90)), 64'd4);
    chk("a_perm_stops", 64'(count_wr(base, 8'h40)), 64'd4);
    chk("a_perm_flags", {error_a, finish_a, busy_a, fail_idx_a}, {1'b1, 1'b0, 1'b0, 8'd0});

    // rty on PRE_HI: identical access after one idle cycle
    base = wn; rty_budget = rty_used + 1;
    pulse_start();
    wait_done("a_rty_timeout");
    chk("a_rty_gap", 64'(re_cyc - rty_cyc), 64'd2);
    chk("a_rty_same", {re_we, re_adr, re_dout}, {1'b1, 3'd1, 8'h00});
    chk("a_rty_count", 64'(wn - base), 64'd15);
    chk("a_rty_flags", {finish_a, error_a}, {1'b1, 1'b0});

    // Second instance: no auto start
    @(negedge clk) act = 1'b1;
    #1 chk_reset("b_reset_vals");
    rst_b = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("b_no_autostart", {busy_b, cyc_b, finish_b}, 3'd0);

    // err on CMD_DAT of entry 5
    base = wn; err_budget = err_used + 1; err_idx = 8'd5;
    pulse_start();
    t = 0;
    while (!error_b && t < 20000) begin @(posedge clk); #1; t++; end
    chk("b_err_timeout", 64'(t < 20000), 64'd1);
    chk("b_err_flags", {error_b, busy_b, finish_b, cyc_b, fail_idx_b}, {4'b1000, 8'd5});
    chk("b_err_count", 64'(wn - base), 64'd38);

    // Reset during POLL_B, then manual restart
    pulse_start();
    t = 0;
    while (!(cyc_b && !we_b && last_cmd == 8'h10) && t < 20000) begin @(posedge clk); #1; t++; end
    chk("b_pollb_timeout", 64'(t < 20000), 64'd1);
    rst_b = 1'b0;
    #1 chk_reset("b_midreset_vals");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("b_idle_after_rst", {busy_b, cyc_b}, 2'd0);
    base = wn;
    pulse_start();
    chk("b_restart_idx", {busy_b, cfg_idx_b}, {1'b1, 8'd0});
    wait_done("b_restart_timeout");
    chk("b_restart_first", {wadr[base], wdat[base]}, {3'd0, 8'h63});
    chk("b_restart_entry0", {wadr[base+5], wdat[base+5], wadr[base+7], wdat[base+7]},
        {3'd3, 8'h30, 3'd3, 8'hC0});
    chk("b_restart_count", 64'(wn - base), 64'd51);
    chk("b_restart_flags", {finish_b, error_b, cfg_idx_b}, {1'b1, 1'b0, 8'd7});

    chk("protocol", 64'(proto_bad), 64'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/i2c_init_seq.md
I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEV_ADDR, 7'h2A, 7-bit I2C slave address.
- N_REGS, 64, number of table entries to write (1..256).
- IDX_W, 8, width of the table index.
- PRESCALE, 16'h0063, value written to the I2C core prescaler.
- MAX_RETRY, 3, NACK retries per entry before failing.
- AUTO_START, 1, start the sequence automatically after reset.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst, in, 1, reset, asynchronous and active-low.
- start, in, 1, one-cycle pulse that (re)runs the sequence.
- cfg_idx, out, IDX_W, table index being fetched.
- cfg_word, in, 16, table entry {reg_addr[15:8], reg_data[7:0]}; valid combinationally from cfg_idx.
- adr, out, 3, Wishbone address to the I2C master core.
- dout, out, 8, Wishbone write data.
- din, in, 8, Wishbone read data.
- we, stb, cyc, out, 1 each, Wishbone controls.
- sel, out, 1, byte select.
- ack, err, rty, in, 1 each, Wishbone terminations.
- busy, out, 1, sequence in progress.
- Finish, out, 1, sticky: all entries written.
- error, out, 1, sticky: sequence aborted.
- fail_idx, out, IDX_W, entry index at abort.

Function
REQ-003 Core register map SHALL be: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR/RXR, 4 CR/SR.
- CR bits: STA=7, STO=6, WR=4.
- SR bits: RxACK=7, Busy=6, TIP=1.

REQ-004 Each Wishbone access SHALL follow these rules:
- cyc=stb=1 and sel=1 from the cycle after the state is entered until the cycle ack, err or rty is sampled high.
- adr, dout and we SHALL be held stable throughout the access.
- cyc and stb SHALL be low in the following cycle.

REQ-005 rty SHALL reissue the identical access after one idle cycle, with no retry limit.

REQ-006 err SHALL abort the sequence: error=1, fail_idx=current index, return to IDLE.

REQ-007 The FSM states SHALL be IDLE, PRE_LO, PRE_HI, EN, LD_DEV, CMD_DEV, POLL_A, LD_REG, CMD_REG, POLL_B, LD_DAT, CMD_DAT, POLL_C, NXT, STOP, POLL_BUSY, DONE.

REQ-008 The initialisation writes SHALL be:
- PRE_LO writes PRESCALE[7:0].
- PRE_HI writes PRESCALE[15:8].
- EN writes CTR=8'h80.

REQ-009 The per-entry writes SHALL be:
- LD_DEV writes TXR={DEV_ADDR,1'b0}; CMD_DEV writes CR=8'h90.
- LD_REG writes TXR=cfg_word[15:8]; CMD_REG writes CR=8'h10.
- LD_DAT writes TXR=cfg_word[7:0]; CMD_DAT writes CR=8'h50.

REQ-010 Each POLL state SHALL read SR (we=0, adr=4) repeatedly until din[1]=0.
- If din[7]=0, proceed to the next state.
- If din[7]=1, go to STOP.

REQ-011 STOP SHALL write CR=8'h40; POLL_BUSY SHALL then read SR until din[6]=0.
- If fewer than MAX_RETRY retries have been used on this entry, increment the retry count and go to LD_DEV.
- Otherwise set error=1 and fail_idx=index, then go to IDLE.

REQ-012 NXT SHALL handle index advance:
- Clear the retry count.
- If index==N_REGS-1, go to DONE; otherwise increment the index and go to LD_DEV.

REQ-013 DONE SHALL set Finish=1 and return to IDLE next cycle.

REQ-014 busy SHALL be 1 in every state except IDLE.

REQ-015 start SHALL be honoured only in IDLE.
- On start: clear Finish, error and the index, then go to PRE_LO.
- start while busy SHALL be ignored.

REQ-016 cfg_idx SHALL equal the current index at all times.

REQ-017 The index SHALL never exceed N_REGS-1 and SHALL not wrap.

REQ-018 The retry counter SHALL be wide enough for MAX_RETRY and SHALL saturate.

Reset
REQ-019 On rst=0, asynchronously, all outputs SHALL go to these values:
- State=IDLE.
- cyc=stb=we=sel=0; adr=0; dout=0.
- cfg_idx=0; busy=0; Finish=0; error=0; fail_idx=0.
- Retry count=0.

REQ-020 When AUTO_START=1, the first cycle after rst deasserts SHALL behave as a start pulse.
- With AUTO_START=0, the block SHALL wait for start.

REQ-021 Reset asserted mid-transfer SHALL drop cyc and stb immediately; no STOP is issued.

Verification
REQ-022 Nominal run, N_REGS=2, all ACKs, RxACK=0:
- Exactly 3+2*6 writes occur, with the correct adr/dout sequence (80, 90, 10, 50, ...).
- Finish=1, error=0.

REQ-023 NACK once on the CMD_REG poll of entry 1:
- CR=8'h40 is written, then entry 1 is retried from LD_DEV.
- Finish=1, error=0.

REQ-024 Permanent NACK on entry 0 with MAX_RETRY=3:
- Exactly 4 address phases and 4 STOPs occur.
- error=1, fail_idx=0, Finish=0.

REQ-025 rty on the PRE_HI write, then ack:
- The same access is reissued after 1 idle cycle; the sequence completes normally.

REQ-026 err on the CMD_DAT write of entry 5:
- error=1, fail_idx=5, busy=0 the cycle after.

REQ-027 rst low during POLL_B, then start after release (AUTO_START=0):
- cyc=0 during reset; all outputs at reset values.
- The sequence restarts at PRE_LO with index 0.
